// File: rtl/pc_fetch_unit.sv
//------------------------------------------------------------------------------
// pc_fetch_unit : 64-bit PC plus single-outstanding instruction fetch stage.
// Optional ack-timeout logic is enabled by defining FETCH_TIMEOUT_EN.
// Revision 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module pc_fetch_unit #(
  parameter int                  PC_WIDTH        = 64,
  parameter int                  IMEM_ADDR_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR    = '0,
  parameter int                  TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 PS,
  input  logic [PC_WIDTH-1:0]        PC_in,
  input  logic [PC_WIDTH-1:0]        br_offset,
  output logic                       imem_req,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_rdata,
  output logic [31:0]                IR,
  output logic                       ir_valid,
  input  logic                       ir_ready,
  output logic [PC_WIDTH-1:0]        PC,
  output logic [PC_WIDTH-1:0]        PC4,
  output logic                       fetch_err
);

  localparam logic [PC_WIDTH-1:0] c_PC_STEP = PC_WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [31:0]         r_ir;
  logic                w_capture;
  logic                w_timeout;
  logic                w_advance;
  logic                w_unused_bits;

`ifdef FETCH_TIMEOUT_EN
  localparam int                 c_CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_wait_cnt;
  logic               r_err;

  // Counter is held at zero outside FETCH, so it is clear on every entry.
  always_ff @(posedge clk) begin
    if (!rst || (r_state != S_FETCH)) begin
      r_wait_cnt <= '0;
    end else if (!imem_ack) begin
      r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign fetch_err     = r_err;
  assign w_unused_bits = ^{PC_in[1:0], br_offset[PC_WIDTH-1:PC_WIDTH-2]};
`else
  assign fetch_err     = 1'b0;
  assign w_unused_bits = ^{PC_in[1:0], br_offset[PC_WIDTH-1:PC_WIDTH-2]} ^ (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (r_wait_cnt == c_TIMEOUT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_HOLD;
        end
`endif
      end
      S_HOLD: begin
        if (ir_ready) begin
          w_advance   = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Branch offset is a word count, so it is scaled by 4 before the add.
  always_comb begin
    w_pc_nxt = r_pc;
    case (PS)
      2'b01:   w_pc_nxt = r_pc + c_PC_STEP;
      2'b10:   w_pc_nxt = {PC_in[PC_WIDTH-1:2], 2'b00};
      2'b11:   w_pc_nxt = r_pc + {br_offset[PC_WIDTH-3:0], 2'b00};
      default: w_pc_nxt = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc <= RESET_VECTOR;
      r_ir <= 32'h0;
    end else begin
      if (w_capture) begin
        r_ir <= imem_rdata;
      end else if (w_timeout) begin
        r_ir <= 32'h0;
      end
      if (w_advance) begin
        r_pc <= w_pc_nxt;
      end
    end
  end

  assign imem_req  = (r_state == S_FETCH);
  assign ir_valid  = (r_state == S_HOLD);
  assign imem_addr = r_pc[IMEM_ADDR_WIDTH+1:2];
  assign IR        = r_ir;
  assign PC        = r_pc;
  assign PC4       = r_pc + c_PC_STEP;

endmodule

`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program counter and instruction-fetch stage directly upstream of the register/ALU/RAM datapath.
- Consumes the datapath's PC_in (register-indirect jump target) and a control-supplied branch offset, and holds the 64-bit PC.
- Fetches 32-bit instructions from a word-addressed instruction memory over a req/ack handshake.
- Presents the instruction register (IR) to the control unit with a valid/ready handshake.

Parameters:
- PC_WIDTH, 64: width of PC, PC_in, br_offset and PC4.
- IMEM_ADDR_WIDTH, 10: instruction memory word-address width. imem_addr = PC[IMEM_ADDR_WIDTH+1:2].
- RESET_VECTOR, 64'h0: PC value loaded on reset. Bits [1:0] must be 0.
- TIMEOUT_CYCLES, 16: ack wait limit, used only when FETCH_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
- PS  input  2  PC select, applied at IR handshake: 00 hold, 01 PC+4, 10 load PC_in, 11 PC+4*br_offset.
- PC_in  input  PC_WIDTH  jump target from the datapath register A path.
- br_offset  input  PC_WIDTH  sign-extended word offset for branches.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  IMEM_ADDR_WIDTH  word address of the fetch.
- imem_ack  input  1  memory returns data this cycle.
- imem_rdata  input  32  instruction word; valid when imem_ack=1.
- IR  output  32  instruction register.
- ir_valid  output  1  IR holds a fetched instruction.
- ir_ready  input  1  control unit accepts IR; PS is sampled in the same cycle.
- PC  output  PC_WIDTH  address of the instruction currently in IR (or being fetched).
- PC4  output  PC_WIDTH  PC+4, combinational; used as the link value.
- fetch_err  output  1  sticky timeout flag; constant 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset (rst=0 at an edge):
  - PC=RESET_VECTOR, IR=32'h0, ir_valid=0, imem_req=0, fetch_err=0, state=IDLE.
  - Takes effect mid-fetch as well: imem_req drops at that edge.
  - An imem_ack arriving while in IDLE is ignored.
- State IDLE: one cycle, then FETCH.
- State FETCH:
  - imem_req=1 and imem_addr=PC[IMEM_ADDR_WIDTH+1:2], both held stable until ack.
  - On imem_ack=1: IR<=imem_rdata, ir_valid<=1, imem_req<=0, next state HOLD.
  - An ack in the first FETCH cycle is legal, giving minimum latency of 1 cycle from req to IR valid.
- State HOLD:
  - ir_valid=1; IR and PC are stable.
  - On ir_valid & ir_ready, at the same edge: PC updates per PS, ir_valid<=0, next state FETCH.
  - Without ir_ready, the block stays in HOLD indefinitely.
- PC update arithmetic, modulo 2^PC_WIDTH with wrap-around and no flag:
  - 00: PC unchanged; the same address is refetched.
  - 01: PC+4.
  - 10: {PC_in[PC_WIDTH-1:2],2'b00}; low bits are silently cleared.
  - 11: PC + (br_offset<<2); negative offsets are allowed.
- PS, PC_in and br_offset are sampled only at the HOLD handshake edge and ignored otherwise.
- Throughput: with ack in the first FETCH cycle and ir_ready held 1, a new instruction is produced every 2 cycles.
- imem_addr truncates the upper PC bits; the PC beyond the memory range aliases.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - An ack-wait counter clears on entry to FETCH and increments each FETCH cycle without ack.
  - When it reaches TIMEOUT_CYCLES: IR<=32'h0, ir_valid<=1, fetch_err<=1 (sticky until reset), state HOLD, imem_req<=0.
  - A late ack arriving in HOLD is ignored.
- Not defined: no counter; FETCH waits forever; fetch_err is tied 0.

Test Plan:
1. Reset, then memory acks each request 1 cycle later with data = word address, ir_ready=1, PS=01:
   - Required: IR sequence 0,1,2,3 at PC 0,4,8,12.
   - Required: imem_req is never high during HOLD.
2. PC=8 in HOLD, PS=10, PC_in=64'h107:
   - Required: next PC=64'h104, imem_addr=10'h041.
3. PC=64'h40, PS=11, br_offset=-4 (all ones <<2 form):
   - Required: PC=64'h30.
   - Then PC=64'hFFFF_FFFF_FFFF_FFFC with PS=01 → PC=0, with no error.
4. ir_ready held 0 for 5 cycles:
   - Required: IR/PC stable, ir_valid=1, no request.
   - Then ir_ready=1 with PS=00 → same address refetched.
5. rst=0 asserted during FETCH, and ack arrives the next cycle:
   - Required: imem_req=0 and PC=RESET_VECTOR at the reset edge, the ack is ignored, and fetch restarts from RESET_VECTOR.
6. With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=16, never ack:
   - Required: after 16 FETCH cycles, IR=0, ir_valid=1, fetch_err=1.
   - fetch_err stays 1 through later successful fetches until reset.
